// File: rtl/lcd_pkg.sv
// Shared types, constants and the command decoder for the HD44780 bus monitor.
// DDRAM is modelled as 32 cells indexed {line, col[3:0]}.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_SETDD,
        OP_ENTRY,
        OP_HOME,
        OP_CLEAR
    } cmd_op_t;

    localparam int         DDRAM_DEPTH = 32;
    localparam logic [7:0] SPACE_CHAR  = 8'h20;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_SETDD = 8'h80;

    // The highest set bit selects the instruction, so test masks from the MSB down.
    function automatic cmd_op_t decode_cmd(input logic [7:0] d);
        cmd_op_t op;
        op = OP_NONE;
        if ((d & CMD_SETDD) != 8'h00)
            op = OP_SETDD;
        else if ((d & 8'hFC) == CMD_ENTRY)
            op = OP_ENTRY;
        else if ((d & 8'hFE) == CMD_HOME)
            op = OP_HOME;
        else if (d == CMD_CLEAR)
            op = OP_CLEAR;
        return op;
    endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Brings the asynchronous LCD bus into the clock domain and flags each falling
// edge of E, presenting rs/rw/data sampled alongside that edge.
module lcd_strobe_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs_in,
    input  logic       rw_in,
    input  logic       en_in,
    input  logic [7:0] data_in,
    output logic       evt,
    output logic       ev_rs,
    output logic       ev_rw,
    output logic [7:0] ev_data
);

    logic [10:0] stage1;
    logic [10:0] stage2;
    logic        en_prev;

    // All bus lines share one pipeline so rs/rw/data stay aligned with E.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1  <= '0;
            stage2  <= '0;
            en_prev <= 1'b0;
        end else begin
            stage1  <= {rs_in, rw_in, en_in, data_in};
            stage2  <= stage1;
            en_prev <= stage2[8];
        end
    end

    assign evt     = en_prev & ~stage2[8];
    assign ev_rs   = stage2[10];
    assign ev_rw   = stage2[9];
    assign ev_data = stage2[7:0];

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 bus monitor: mirrors DDRAM writes, reports characters and
// commands, and emulates the controller busy flag.
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 50,
    parameter int CLEAR_CYCLES = 2000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       char_valid,
    output logic [7:0] char_code,
    output logic [4:0] char_addr,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       busy,
    output logic       proto_err
);

    localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_SPAN = CNT_W'(DDRAM_DEPTH);

    logic       evt;
    logic       ev_rs;
    logic       ev_rw;
    logic [7:0] ev_data;

    state_t           state;
    state_t           next_state;
    cmd_op_t          op;
    logic             accept;
    logic             drop;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       addr;
    logic             id;
    logic [7:0]       ddram [DDRAM_DEPTH];

    lcd_strobe_sync u_sync (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .rs_in   (lcd_rs),
        .rw_in   (lcd_rw),
        .en_in   (lcd_en),
        .data_in (lcd_data),
        .evt     (evt),
        .ev_rs   (ev_rs),
        .ev_rw   (ev_rw),
        .ev_data (ev_data)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Read strobes are ignored entirely; writes are taken only when idle.
    always_comb begin
        op         = decode_cmd(ev_data);
        accept     = 1'b0;
        drop       = 1'b0;
        next_state = state;
        if (evt && !ev_rw) begin
            if (state == IDLE)
                accept = 1'b1;
            else
                drop = 1'b1;
        end
        case (state)
            IDLE: begin
                if (accept)
                    next_state = (!ev_rs && op == OP_CLEAR) ? CLEAR : EXEC;
            end
            EXEC: begin
                if (cnt == BUSY_LAST)
                    next_state = IDLE;
            end
            CLEAR: begin
                if (cnt == CLEAR_LAST)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            cnt <= '0;
        else if (next_state != state)
            cnt <= '0;
        else if (state != IDLE)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            addr <= 5'd0;
            id   <= 1'b1;
        end else if (accept) begin
            if (ev_rs) begin
                addr <= id ? addr + 5'd1 : addr - 5'd1;
            end else begin
                case (op)
                    OP_SETDD: addr <= {ev_data[6], ev_data[3:0]};
                    OP_ENTRY: id   <= ev_data[1];
                    OP_HOME:  addr <= 5'd0;
                    OP_CLEAR: begin
                        addr <= 5'd0;
                        id   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The clear sweep uses the low counter bits as the cell index for its first 32 cycles.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < DDRAM_DEPTH; i++)
                ddram[i] <= SPACE_CHAR;
        end else if (accept && ev_rs) begin
            ddram[addr] <= ev_data;
        end else if (state == CLEAR && cnt < CLEAR_SPAN) begin
            ddram[cnt[4:0]] <= SPACE_CHAR;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            char_valid <= 1'b0;
            char_code  <= 8'h00;
            char_addr  <= 5'd0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 8'h00;
            proto_err  <= 1'b0;
        end else begin
            char_valid <= accept & ev_rs;
            cmd_valid  <= accept & ~ev_rs;
            proto_err  <= drop;
            if (accept && ev_rs) begin
                char_code <= ev_data;
                char_addr <= addr;
            end
            if (accept && !ev_rs)
                cmd_code <= ev_data;
        end
    end

    assign busy    = (state != IDLE);
    assign rd_data = ddram[rd_addr];

endmodule

// File: doc/lcd_bus_monitor.md
LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

Interface
REQ-001 Parameter BUSY_CYCLES, default 50: clk_clk cycles busy stays high after a non-clear write.
REQ-002 Parameter CLEAR_CYCLES, default 2000: clk_clk cycles busy stays high after a clear command; must be >= 32.
REQ-003 clk_clk  in  1  sole clock, rising edge.
REQ-004 reset_reset  in  1  asynchronous, active-high reset.
REQ-005 lcd_rs  in  1  register select: 0 = command, 1 = data; asynchronous to clk_clk.
REQ-006 lcd_rw  in  1  1 = read strobe, 0 = write strobe; asynchronous.
REQ-007 lcd_en  in  1  enable strobe; a write is taken on its falling edge; asynchronous.
REQ-008 lcd_data  in  8  DB[7:0]; asynchronous.
REQ-009 rd_addr  in  5  DDRAM read address for host inspection.
REQ-010 rd_data  out  8  DDRAM[rd_addr], combinational.
REQ-011 char_valid  out  1  one-cycle pulse: a character was stored.
REQ-012 char_code  out  8  character stored, valid with char_valid.
REQ-013 char_addr  out  5  DDRAM index written, valid with char_valid.
REQ-014 cmd_valid  out  1  one-cycle pulse: a command byte was accepted.
REQ-015 cmd_code  out  8  accepted command byte, valid with cmd_valid.
REQ-016 busy  out  1  emulated HD44780 busy flag.
REQ-017 proto_err  out  1  one-cycle pulse: a write arrived while busy and was dropped.

Function
REQ-018 lcd_rs, lcd_rw, lcd_en and lcd_data shall pass through a 2-flop synchronizer; a strobe event is the first cycle where synced E = 0 and the previous synced E = 1.
REQ-019 Strobe events with lcd_rw = 1 shall be ignored: no output or state change.
REQ-020 A write event (lcd_rw = 0) while busy = 1 or state != IDLE shall be dropped, with proto_err high for exactly the next cycle.
REQ-021 An accepted data write (lcd_rs = 1) shall store the byte at the current address; char_valid, char_code and char_addr are asserted the cycle after the event.
REQ-022 After the data write, the address shall step by +1 if ID = 1, else by -1, and wrap modulo 32 (31+1 -> 0, 0-1 -> 31).
REQ-023 Internal index = {line, col}; DDRAM 0x00-0x0F maps to 0-15 and 0x40-0x4F maps to 16-31.
REQ-024 Commands (lcd_rs = 0) are decoded by priority from the MSB:
 - 0x80-0xFF: address = {d[6], d[3:0]}; d[5:4] are ignored.
 - 0x04-0x07: ID = d[1].
 - 0x02-0x03: address = 0.
 - 0x01: clear.
 - all others: cmd_valid only, no state change.
REQ-025 Every accepted command shall pulse cmd_valid with cmd_code the cycle after the event.
REQ-026 FSM states and transitions:
 - IDLE -> EXEC on any accepted non-clear write.
 - IDLE -> CLEAR on 0x01.
 - EXEC -> IDLE after BUSY_CYCLES.
 - CLEAR -> IDLE after CLEAR_CYCLES.
REQ-027 CLEAR shall write 0x20 to DDRAM[0..31], one location per cycle over its first 32 cycles, and set address = 0 and ID = 1.
REQ-028 busy shall be 1 exactly while state != IDLE, starting the cycle after the event.
REQ-029 Host reads via rd_addr shall never disturb write state; a read during CLEAR returns the partially cleared contents.

Reset
REQ-030 reset_reset shall force the following immediately, independent of clk_clk:
 - state IDLE; address 0; ID 1; busy counter 0; synchronizer flops 0.
 - all 32 DDRAM entries 0x20.
 - outputs char_valid, cmd_valid, busy, proto_err, char_code, char_addr and cmd_code all 0.
REQ-031 Reset asserted during EXEC or CLEAR shall abort the operation with no residual pulses after release.
REQ-032 A strobe event whose falling edge completes within 2 cycles after reset release may be lost, but shall never be partially applied.

Structure
REQ-033 Package lcd_pkg shall hold:
 - state typedef (IDLE, EXEC, CLEAR);
 - DDRAM_DEPTH = 32;
 - SPACE_CHAR = 8'h20;
 - command masks CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_SETDD.
REQ-034 Sub-module lcd_strobe_sync shall contain the synchronizer and falling-edge detect, and output the captured rs/rw/data plus an event pulse.

Verification
REQ-035 After reset, rd_data = 0x20 for rd_addr 0..31 and busy = 0.
REQ-036 Write cmd 0xC5, then data 0x41: char_addr = 21, char_code = 0x41, DDRAM[21] = 0x41, address becomes 22.
REQ-037 Write cmd 0x04 (ID = 0) and address 0x80, then data 0x42: char_addr = 0, then address = 31; next data 0x43 lands at 31.
REQ-038 Write 0x01 while DDRAM holds data: busy is high for CLEAR_CYCLES, then all locations read 0x20 and address = 0.
REQ-039 Data write issued 10 cycles into EXEC: proto_err pulses once, DDRAM is unchanged, char_valid stays 0.
REQ-040 Assert reset_reset mid-CLEAR at location 12: busy = 0 immediately, all locations read 0x20, and no cmd_valid or char_valid follows release.
